data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares the single-port 16x8 data memory between two requesters: port 0 (processor load/store unit) and port 1 (perceptron accelerator).
- Grants at most one access per cycle, round-robin on conflict.
- Optional lock holds ownership across multiple beats for atomic read-modify-write.
- Drives the memory's write enable, address and write data directly; returns read data to the winner one cycle later.

Parameters:
- ADDR_W, 4, memory address width (16 words)
- DATA_W, 8, memory word width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  port 0 access request
- req0_we  in  1  1 = write, 0 = read
- req0_lock  in  1  keep ownership after this beat
- req0_addr  in  ADDR_W  word address
- req0_wdata  in  DATA_W  write data
- req0_ready  out  1  beat accepted this cycle
- req0_rvalid  out  1  read data valid (one cycle)
- req0_rdata  out  DATA_W  read data
- req1_*  same set as req0_*, for port 1
- mem_write_en  out  1  to memory write enable
- mem_addr  out  ADDR_W  to memory address
- mem_write_data  out  DATA_W  to memory write data
- mem_read_data  in  DATA_W  from memory (asynchronous read)

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: state=IDLE, last_grant=1 (port 0 wins the first conflict), req*_rvalid=0, req*_rdata=0.
- Combinational outputs: req*_ready, mem_write_en, mem_addr, mem_write_data. None depend on rvalid.
- Handshake: a beat transfers when valid&&ready. Requester holds we/lock/addr/wdata stable while valid&&!ready.
- Grant in IDLE:
  - Only one valid: that port is granted.
  - Both valid: grant the port != last_grant.
  - last_grant updates to the granted port on every transferred beat.
- FSM states: IDLE, OWN0, OWN1.
  - IDLE -> OWNn when port n transfers a beat with lockn=1.
  - OWNn: only port n may be granted. The other port's ready=0, even if port n is not valid.
  - OWNn -> IDLE when port n transfers a beat with lockn=0.
  - OWNn stays in OWNn while port n is idle or transfers locked beats.
- Memory drive:
  - mem_addr and mem_write_data come from the granted port.
  - With no grant, they come from port 0 and mem_write_en=0.
  - mem_write_en = grant && granted port's we.
- Read latency:
  - Read beat in cycle T: reqn_rdata is registered from mem_read_data at edge T+1, and reqn_rvalid=1 during cycle T+1 only.
  - rdata holds its value after rvalid falls.
  - The other port's rvalid stays 0.
- Write: memory updates at edge T+1. No response pulse.
- Back-to-back: a write at T followed by a read of the same address at T+1 returns the new data.
- Throughput: one beat per cycle, sustained. Zero bubbles between ports or between beats.
- Reset mid-operation:
  - State returns to IDLE and last_grant returns to 1.
  - Any pending rvalid is squashed to 0.
  - A beat presented in the reset cycle is not granted (ready=0, mem_write_en=0).
- No address range check is needed: ADDR_W covers the full memory.

Decomposition:
- Package data_mem_arb_pkg holds:
  - ADDR_W and DATA_W defaults
  - state enum {IDLE, OWN0, OWN1}
  - port index constants PORT_CPU=0, PORT_ACC=1
- Sub-module rr_arb2: two-input round-robin grant.
  - Inputs: req[1:0], last_grant, enable.
  - Output: one-hot gnt[1:0].
  - Purely combinational.
- The FSM, lock handling and response registers stay in data_mem_arbiter.

Test Plan:
- Single read: preload mem[3]=8'hA5; port0 read addr 3 at cycle T -> req0_ready=1 at T; req0_rvalid=1, req0_rdata=A5 at T+1; req1_rvalid=0.
- Conflict round-robin: both ports hold valid reads (port0 addr 1, port1 addr 2) for 4 cycles after reset -> grant order 0,1,0,1; the non-granted port sees ready=0 each cycle.
- Write then read: port1 writes 8'h3C to addr 15 at T, reads addr 15 at T+1 -> mem_write_en=1 only at T; req1_rdata=3C with rvalid at T+2.
- Lock RMW:
  - Port1 reads addr 5 with lock=1 while port0 is valid -> port0 ready=0 through a 2-cycle port1 gap.
  - Port1 then writes addr 5 with lock=0 -> state returns to IDLE; port0 is granted the next cycle.
- Reset mid-lock: in OWN0 with a read rvalid due, assert rst for one cycle -> rvalid=0, state IDLE; next simultaneous request grants port 0.
- Idle: no valid for 10 cycles -> mem_write_en=0, both ready=0, both rvalid=0 throughout.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// Shared types and defaults for the data memory arbiter.
// Port 0 is the load/store unit, port 1 the perceptron accelerator.
package data_mem_arb_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_ACC = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant, purely combinational.
// On conflict the port that did not win last time is granted.
module rr_arb2
  import data_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] gnt
);
  logic w_both;

  assign w_both = req[PORT_CPU] & req[PORT_ACC];

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      if (w_both) begin
        gnt[PORT_CPU] = (last_grant == PORT_ACC);
        gnt[PORT_ACC] = (last_grant == PORT_CPU);
      end else begin
        gnt = req;
      end
    end
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data memory between the CPU and the
// accelerator, with a lock for atomic read-modify-write sequences.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic              req0_lock,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic              req1_lock,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);
  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              r_last_grant;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_any;
  logic              w_sel;
  logic              w_sel_we;
  logic              w_sel_lock;
  logic              w_rd0;
  logic              w_rd1;

  // An owner masks the other port even while the owner is idle
  always_comb begin
    w_req = {req1_valid, req0_valid};
    case (r_state)
      OWN0:    w_req = {1'b0, req0_valid};
      OWN1:    w_req = {req1_valid, 1'b0};
      default: w_req = {req1_valid, req0_valid};
    endcase
  end

  rr_arb2 u_rr_arb2 (
    .req        (w_req),
    .last_grant (r_last_grant),
    .enable     (!rst),
    .gnt        (w_gnt)
  );

  assign w_any      = |w_gnt;
  assign w_sel      = w_gnt[PORT_ACC];
  assign w_sel_we   = w_sel ? req1_we : req0_we;
  assign w_sel_lock = w_sel ? req1_lock : req0_lock;
  assign w_rd0      = w_gnt[PORT_CPU] & ~req0_we;
  assign w_rd1      = w_gnt[PORT_ACC] & ~req1_we;

  assign req0_ready     = w_gnt[PORT_CPU];
  assign req1_ready     = w_gnt[PORT_ACC];
  assign mem_write_en   = w_any & w_sel_we;
  assign mem_addr       = w_sel ? req1_addr : req0_addr;
  assign mem_write_data = w_sel ? req1_wdata : req0_wdata;
  assign req0_rvalid    = r_rvalid0;
  assign req1_rvalid    = r_rvalid1;
  assign req0_rdata     = r_rdata0;
  assign req1_rdata     = r_rdata1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_any && w_sel_lock) begin
          w_state_nxt = w_sel ? OWN1 : OWN0;
        end
      end
      OWN0, OWN1: begin
        if (w_any && !w_sel_lock) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= PORT_ACC;
      r_rvalid0    <= 1'b0;
      r_rvalid1    <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rvalid0 <= w_rd0;
      r_rvalid1 <= w_rd1;
      if (w_any) begin
        r_last_grant <= w_sel;
      end
      if (w_rd0) begin
        r_rdata0 <= mem_read_data;
      end
      if (w_rd1) begin
        r_rdata1 <= mem_read_data;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: a transaction-level model
// predicts grants and read data, a monitor checks read responses.
module tb_data_mem_arbiter;
  typedef struct {
    int         c;
    logic [7:0] d;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v[2];
  logic       wr[2];
  logic       lk[2];
  logic [3:0] ad[2];
  logic [7:0] wd[2];
  logic       held[2];

  logic       req0_ready, req1_ready;
  logic       req0_rvalid, req1_rvalid;
  logic [7:0] req0_rdata, req1_rdata;
  logic       mem_write_en;
  logic [3:0] mem_addr;
  logic [7:0] mem_write_data;
  logic [7:0] mem_read_data;

  logic [7:0] dmem[16];
  logic [7:0] ref_mem[16];
  exp_t       q0[$];
  exp_t       q1[$];
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;

  data_mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .req0_valid     (v[0]),
    .req0_we        (wr[0]),
    .req0_lock      (lk[0]),
    .req0_addr      (ad[0]),
    .req0_wdata     (wd[0]),
    .req0_ready     (req0_ready),
    .req0_rvalid    (req0_rvalid),
    .req0_rdata     (req0_rdata),
    .req1_valid     (v[1]),
    .req1_we        (wr[1]),
    .req1_lock      (lk[1]),
    .req1_addr      (ad[1]),
    .req1_wdata     (wd[1]),
    .req1_ready     (req1_ready),
    .req1_rvalid    (req1_rvalid),
    .req1_rdata     (req1_rdata),
    .mem_write_en   (mem_write_en),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  // Memory behind the arbiter: async read, write on the edge
  assign mem_read_data = dmem[mem_addr];
  always @(posedge clk) begin
    if (mem_write_en) dmem[mem_addr] <= mem_write_data;
    cyc <= cyc + 1;
  end

  task automatic chk(input string n, input logic [7:0] act,
                     input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               n, act, exp, cyc);
    end
  endtask

  task automatic setp(input int p, input logic vv, input logic w,
                      input logic l, input logic [3:0] a,
                      input logic [7:0] d);
    v[p] = vv; wr[p] = w; lk[p] = l; ad[p] = a; wd[p] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: owner (-1 none), last winner, memory contents
  initial begin
    int owner;
    int last;
    int g;
    bit e0, e1;
    exp_t e;
    owner = -1;
    last = 1;
    @(posedge clk);
    forever begin
      @(negedge clk);
      g = -1;
      if (!rst) begin
        e0 = v[0] && owner != 1;
        e1 = v[1] && owner != 0;
        if (e0 && e1) g = 1 - last;
        else if (e0) g = 0;
        else if (e1) g = 1;
      end
      chk("ready0", {7'd0, req0_ready}, {7'd0, g == 0});
      chk("ready1", {7'd0, req1_ready}, {7'd0, g == 1});
      chk("mem_we", {7'd0, mem_write_en},
          {7'd0, (g >= 0) ? wr[g] : 1'b0});
      if (g >= 0) begin
        chk("mem_addr", {4'd0, mem_addr}, {4'd0, ad[g]});
        if (wr[g]) chk("mem_wdata", mem_write_data, wd[g]);
      end
      if (rst) begin
        owner = -1;
        last = 1;
      end else if (g >= 0) begin
        last = g;
        owner = lk[g] ? g : -1;
        if (wr[g]) begin
          ref_mem[ad[g]] = wd[g];
        end else begin
          e.c = cyc;
          e.d = ref_mem[ad[g]];
          if (g == 0) q0.push_back(e);
          else q1.push_back(e);
        end
      end
      held[0] = v[0] && g != 0;
      held[1] = v[1] && g != 1;
    end
  end

  // Monitor: a response is due exactly one cycle after its read beat
  initial begin
    exp_t e;
    bit ev;
    @(posedge clk);
    forever begin
      @(negedge clk);
      ev = q0.size() > 0 && q0[0].c == cyc - 1;
      chk("rvalid0", {7'd0, req0_rvalid}, {7'd0, ev});
      if (ev) begin
        e = q0.pop_front();
        chk("rdata0", req0_rdata, e.d);
      end
      ev = q1.size() > 0 && q1[0].c == cyc - 1;
      chk("rvalid1", {7'd0, req1_rvalid}, {7'd0, ev});
      if (ev) begin
        e = q1.pop_front();
        chk("rdata1", req1_rdata, e.d);
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      dmem[i] = 8'($urandom);
      ref_mem[i] = dmem[i];
    end
    dmem[3] = 8'hA5;
    ref_mem[3] = 8'hA5;
    held[0] = 1'b0;
    held[1] = 1'b0;
    setp(0, 0, 0, 0, 0, 0);
    setp(1, 0, 0, 0, 0, 0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    setp(0, 1, 0, 0, 4'd3, 0);
    step();
    setp(0, 1, 0, 0, 4'd1, 0);
    setp(1, 1, 0, 0, 4'd2, 0);
    repeat (4) step();
    setp(0, 0, 0, 0, 0, 0);
    setp(1, 0, 0, 0, 0, 0);
    repeat (10) step();
    setp(1, 1, 1, 0, 4'd15, 8'h3C);
    step();
    setp(1, 1, 0, 0, 4'd15, 0);
    step();
    setp(1, 1, 0, 1, 4'd5, 0);
    step();
    setp(1, 0, 0, 0, 0, 0);
    setp(0, 1, 0, 0, 4'd7, 0);
    repeat (2) step();
    setp(1, 1, 1, 0, 4'd5, 8'h5A);
    step();
    setp(1, 0, 0, 0, 0, 0);
    step();
    setp(0, 1, 0, 1, 4'd3, 0);
    step();
    rst = 1'b1;
    setp(1, 1, 0, 0, 4'd4, 0);
    step();
    rst = 1'b0;
    step();
    setp(0, 0, 0, 0, 0, 0);
    setp(1, 0, 0, 0, 0, 0);
    repeat (2) step();
    for (int i = 0; i < 3000; i++) begin
      step();
      rst = ($urandom_range(0, 99) < 2);
      for (int p = 0; p < 2; p++) begin
        if (!held[p]) begin
          setp(p, $urandom_range(0, 9) < 7,
               $urandom_range(0, 9) < 4,
               $urandom_range(0, 3) == 0,
               4'($urandom), 8'($urandom));
        end
      end
    end
    step();
    rst = 1'b0;
    setp(0, 0, 0, 0, 0, 0);
    setp(1, 0, 0, 0, 0, 0);
    repeat (4) step();
    chk("drain0", 8'(q0.size()), 8'd0);
    chk("drain1", 8'(q1.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
